// File: rtl/proj_pkg.sv
// Shared types and default constants for the projectile engine.
package proj_pkg;

    // Direction of travel. It is latched at launch and never follows later facing changes.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } dir_t;

    // Coordinate storage inside the slot struct is sized for the widest supported COORD_W.
    // Each slot only ever writes its low COORD_W bits.
    localparam int MAX_COORD_W = 16;

    localparam int DEF_COORD_W    = 10;
    localparam int DEF_SPEED      = 5;
    localparam int DEF_COOLDOWN   = 16;
    localparam int DEF_MUZZLE_OFS = 40;
    localparam int DEF_Y_LAUNCH   = 340;
    localparam int DEF_X_MAX      = 639;

    // State of one projectile slot. An inactive slot holds all zeros.
    typedef struct packed {
        logic                   active;
        dir_t                   dir;
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
    } proj_slot_t;

endpackage

// File: rtl/projectile_slot.sv
// One projectile slot: load at launch, per-frame motion, edge despawn, clear on hit.
module projectile_slot
    import proj_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int SPEED   = DEF_SPEED,
    parameter int X_MAX   = DEF_X_MAX
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    input  logic               load_dir,
    input  logic               hit,
    output logic               active,
    output logic               dir,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    // One extra bit so that an underflow or overflow of the x coordinate can be seen.
    localparam int EXT_W = COORD_W + 1;

    proj_slot_t       slot_q;
    proj_slot_t       slot_d;
    logic [EXT_W-1:0] x_ext;
    logic [EXT_W-1:0] x_moved;
    logic             off_screen;

    // Next state: start-screen clear, then hit, then motion/despawn; an idle slot may load.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        slot_d     = slot_q;
        x_ext      = EXT_W'(slot_q.x);
        x_moved    = (slot_q.dir == RIGHT) ? x_ext + EXT_W'(SPEED) : x_ext - EXT_W'(SPEED);
        off_screen = x_moved[COORD_W] || (x_moved > EXT_W'(X_MAX));

        if (clear) begin
            slot_d = '0;
        end else if (slot_q.active) begin
            if (hit || off_screen) begin
                slot_d = '0;
            end else begin
                slot_d.x = MAX_COORD_W'(x_moved[COORD_W-1:0]);
            end
        end else if (load) begin
            // A hit on an idle slot is ignored, so it cannot block a launch.
            slot_d.active = 1'b1;
            slot_d.dir    = dir_t'(load_dir);
            slot_d.x      = MAX_COORD_W'(load_x);
            slot_d.y      = MAX_COORD_W'(load_y);
        end
    end

    // Slot state register, cleared asynchronously on reset.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign active = slot_q.active;
    assign dir    = slot_q.dir;
    assign x      = COORD_W'(slot_q.x);
    assign y      = COORD_W'(slot_q.y);

endmodule

// File: rtl/projectile_engine.sv
// Projectile manager: per-player fire edge detection, cooldown and slot allocation over a
// players-by-slots array of projectile_slot instances.
module projectile_engine
    import proj_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SLOTS       = 2,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int SPEED       = DEF_SPEED,
    parameter int COOLDOWN    = DEF_COOLDOWN,
    parameter int MUZZLE_OFS  = DEF_MUZZLE_OFS,
    parameter int Y_LAUNCH    = DEF_Y_LAUNCH,
    parameter int X_MAX       = DEF_X_MAX
) (
    input  logic                                 frame_clk,
    input  logic                                 Reset_n,
    input  logic                                 enable,
    input  logic [NUM_PLAYERS-1:0]               shoot,
    input  logic [NUM_PLAYERS-1:0]               facing_right,
    input  logic [NUM_PLAYERS*COORD_W-1:0]       sprite_x,
    input  logic [NUM_PLAYERS*SLOTS-1:0]         hit,
    output logic [NUM_PLAYERS*SLOTS-1:0]         proj_active,
    output logic [NUM_PLAYERS*SLOTS*COORD_W-1:0] proj_x,
    output logic [NUM_PLAYERS*SLOTS*COORD_W-1:0] proj_y,
    output logic [NUM_PLAYERS*SLOTS-1:0]         proj_dir,
    output logic [NUM_PLAYERS-1:0]               fire_event
);

    localparam int EXT_W = COORD_W + 1;
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0]    CD_LOAD  = CD_W'(COOLDOWN);
    localparam logic [COORD_W-1:0] LAUNCH_Y = COORD_W'(Y_LAUNCH);

    logic [NUM_PLAYERS-1:0]       shoot_q;
    logic [NUM_PLAYERS-1:0]       rise;
    logic [NUM_PLAYERS-1:0]       fire_req;
    logic [NUM_PLAYERS-1:0]       fire_ok;
    logic [NUM_PLAYERS*SLOTS-1:0] load;
    logic [EXT_W-1:0]             launch_ext [NUM_PLAYERS];
    logic [CD_W-1:0]              cooldown   [NUM_PLAYERS];

    assign rise = shoot & ~shoot_q;

    // Launch position, fire acceptance and lowest-free-slot allocation for each player.
    always_comb begin
        load     = '0;
        fire_req = '0;
        fire_ok  = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (facing_right[p]) begin
                launch_ext[p] = {1'b0, sprite_x[p*COORD_W +: COORD_W]} + EXT_W'(MUZZLE_OFS);
            end else if ({1'b0, sprite_x[p*COORD_W +: COORD_W]} < EXT_W'(MUZZLE_OFS)) begin
                launch_ext[p] = '0;
            end else begin
                launch_ext[p] = {1'b0, sprite_x[p*COORD_W +: COORD_W]} - EXT_W'(MUZZLE_OFS);
            end

            fire_req[p] = enable && rise[p] && (cooldown[p] == '0) &&
                          (launch_ext[p] <= EXT_W'(X_MAX));

            // Slot occupancy is judged on the registered (pre-edge) active flags.
            for (int s = 0; s < SLOTS; s++) begin
                if (fire_req[p] && !fire_ok[p] && !proj_active[p*SLOTS+s]) begin
                    load[p*SLOTS+s] = 1'b1;
                    fire_ok[p]      = 1'b1;
                end
            end
        end
    end

    // Edge-detect history, fire pulse and per-player cooldown counters.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shoot_q    <= '0;
            fire_event <= '0;
            // NOTE: this small counter array is reset explicitly because zero means "may fire".
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                cooldown[p] <= '0;
            end
        end else begin
            // shoot_q tracks shoot even on the start screen so a held button never fires later.
            shoot_q <= shoot;
            if (!enable) begin
                fire_event <= '0;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    cooldown[p] <= '0;
                end
            end else begin
                fire_event <= fire_ok;
                for (int p = 0; p < NUM_PLAYERS; p++) begin
                    if (fire_ok[p]) begin
                        cooldown[p] <= CD_LOAD;
                    end else if (cooldown[p] != '0) begin
                        cooldown[p] <= cooldown[p] - CD_W'(1);
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar s = 0; s < SLOTS; s++) begin : g_slot
            localparam int IDX = p * SLOTS + s;

            projectile_slot #(
                .COORD_W (COORD_W),
                .SPEED   (SPEED),
                .X_MAX   (X_MAX)
            ) u_slot (
                .frame_clk (frame_clk),
                .Reset_n   (Reset_n),
                .clear     (!enable),
                .load      (load[IDX]),
                .load_x    (launch_ext[p][COORD_W-1:0]),
                .load_y    (LAUNCH_Y),
                .load_dir  (facing_right[p]),
                .hit       (hit[IDX]),
                .active    (proj_active[IDX]),
                .dir       (proj_dir[IDX]),
                .x         (proj_x[IDX*COORD_W +: COORD_W]),
                .y         (proj_y[IDX*COORD_W +: COORD_W])
            );
        end
    end

endmodule

// File: tb/tb_projectile_engine.sv
// Scoreboard bench for projectile_engine: stimulus queues frame-tagged expectations,
// a monitor compares them against the DUT on each falling clock edge.
module tb_projectile_engine;

    localparam int NP  = 2;
    localparam int NS  = 2;
    localparam int CW  = 10;
    localparam int NSL = NP * NS;

    logic              frame_clk = 1'b0;
    logic              Reset_n;
    logic              enable;
    logic [NP-1:0]     shoot;
    logic [NP-1:0]     facing_right;
    logic [NP*CW-1:0]  sprite_x;
    logic [NSL-1:0]    hit;
    logic [NSL-1:0]    proj_active;
    logic [NSL*CW-1:0] proj_x;
    logic [NSL*CW-1:0] proj_y;
    logic [NSL-1:0]    proj_dir;
    logic [NP-1:0]     fire_event;

    projectile_engine #(
        .NUM_PLAYERS (NP),
        .SLOTS       (NS),
        .COORD_W     (CW),
        .SPEED       (5),
        .COOLDOWN    (16),
        .MUZZLE_OFS  (40),
        .Y_LAUNCH    (340),
        .X_MAX       (639)
    ) dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .enable       (enable),
        .shoot        (shoot),
        .facing_right (facing_right),
        .sprite_x     (sprite_x),
        .hit          (hit),
        .proj_active  (proj_active),
        .proj_x       (proj_x),
        .proj_y       (proj_y),
        .proj_dir     (proj_dir),
        .fire_event   (fire_event)
    );

    always #5 frame_clk = ~frame_clk;

    // Frame number: counts rising edges; expectations are tagged with the frame they apply to.
    int cyc = 0;
    always @(posedge frame_clk) cyc <= cyc + 1;

    typedef enum {K_ACT, K_X, K_Y, K_DIR, K_FEV} kind_e;
    typedef struct {
        int    frame;
        kind_e kind;
        int    idx;
        int    value;
        string name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(string name, int actual, int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s @frame %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Queue an expectation dt frames ahead, keeping the queue sorted by frame.
    task automatic expect_at(int dt, kind_e kind, int idx, int value, string name);
        exp_t e;
        int   j;
        e.frame = cyc + dt;
        e.kind  = kind;
        e.idx   = idx;
        e.value = value;
        e.name  = name;
        j = exp_q.size();
        while (j > 0 && exp_q[j-1].frame > e.frame) j--;
        exp_q.insert(j, e);
    endtask

    function automatic int observe(kind_e kind, int idx);
        case (kind)
            K_ACT:   return int'(proj_active);
            K_X:     return int'(proj_x[idx*CW +: CW]);
            K_Y:     return int'(proj_y[idx*CW +: CW]);
            K_DIR:   return int'(proj_dir[idx]);
            default: return int'(fire_event);
        endcase
    endfunction

    // Monitor: on each falling edge, compare every expectation due for the current frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge frame_clk);
            while (exp_q.size() > 0 && exp_q[0].frame <= cyc) begin
                e = exp_q.pop_front();
                if (e.frame < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: expectation for frame %0d was never compared", e.name, e.frame);
                end else begin
                    check(e.name, observe(e.kind, e.idx), e.value);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One frame with enable low: clears every slot and cooldown, releases all buttons.
    task automatic clean();
        enable = 1'b0;
        shoot  = '0;
        hit    = '0;
        @(negedge frame_clk);
        enable = 1'b1;
    endtask

    initial begin
        Reset_n      = 1'b0;
        enable       = 1'b1;
        shoot        = '0;
        facing_right = 2'b01;
        sprite_x     = {10'd30, 10'd200};
        hit          = '0;

        // Reset state.
        @(posedge frame_clk);
        #2;
        expect_at(0, K_ACT, 0, 0, "rst_active");
        expect_at(0, K_X,   0, 0, "rst_x0");
        expect_at(0, K_Y,   0, 0, "rst_y0");
        expect_at(0, K_DIR, 0, 0, "rst_dir0");
        expect_at(0, K_FEV, 0, 0, "rst_fire_event");
        @(negedge frame_clk);
        Reset_n = 1'b1;

        // A: P0 fires facing right from x=200, then holds the button for 50 frames.
        clean();
        shoot = 2'b01;
        expect_at(1, K_ACT, 0, 4'b0001, "a_active");
        expect_at(1, K_X,   0, 240, "a_launch_x");
        expect_at(1, K_Y,   0, 340, "a_launch_y");
        expect_at(1, K_DIR, 0, 1,   "a_dir");
        expect_at(1, K_FEV, 0, 2'b01, "a_fire_event");
        expect_at(2, K_X,   0, 245, "a_move1");
        expect_at(3, K_X,   0, 250, "a_move2");
        expect_at(4, K_X,   0, 255, "a_move3");
        expect_at(50, K_X,  0, 485, "a_move49");
        expect_at(50, K_ACT, 0, 4'b0001, "a_single_fire");
        for (int d = 2; d <= 50; d++) expect_at(d, K_FEV, 0, 0, "a_hold_no_refire");
        repeat (50) @(negedge frame_clk);
        shoot = '0;

        // B: toggle every 4 frames; cooldown then full slots gate the fires; hit frees slot 1.
        clean();
        expect_at(1,  K_X,   0, 240, "b_slot0_launch");
        expect_at(21, K_X,   1, 240, "b_slot1_launch");
        expect_at(22, K_X,   1, 245, "b_slot1_move");
        expect_at(48, K_ACT, 0, 4'b0011, "b_both_full");
        expect_at(48, K_X,   0, 475, "b_slot0_x");
        expect_at(48, K_X,   1, 375, "b_slot1_x");
        for (int i = 0; i < 48; i++) begin
            shoot[0] = ((i % 4) < 2);
            expect_at(1, K_FEV, 0, (i == 0 || i == 20) ? 1 : 0, "b_cooldown_fire");
            @(negedge frame_clk);
        end
        shoot = '0;
        hit   = 4'b0010;
        expect_at(1, K_ACT, 0, 4'b0001, "b_hit_active");
        expect_at(1, K_X,   1, 0,   "b_hit_x1");
        expect_at(1, K_X,   0, 480, "b_slot0_keeps_moving");
        @(negedge frame_clk);
        hit   = '0;
        shoot = 2'b01;
        expect_at(1, K_ACT, 0, 4'b0011, "b_realloc_active");
        expect_at(1, K_X,   1, 240, "b_realloc_x1");
        expect_at(1, K_X,   0, 485, "b_realloc_x0");
        expect_at(1, K_FEV, 0, 2'b01, "b_realloc_fire_event");
        expect_at(2, K_X,   1, 245, "b_realloc_move_x1");
        expect_at(2, K_X,   0, 490, "b_realloc_move_x0");
        expect_at(2, K_FEV, 0, 0,   "b_realloc_pulse_end");
        repeat (2) @(negedge frame_clk);
        shoot = '0;

        // C: P1 at x=30 facing left saturates to 0 and despawns; a hit on the idle slot is ignored.
        clean();
        sprite_x[CW +: CW] = 10'd30;
        facing_right = 2'b01;
        shoot        = 2'b10;
        hit          = 4'b0100;
        expect_at(1, K_ACT, 0, 4'b0100, "c_active");
        expect_at(1, K_X,   2, 0,   "c_launch_sat");
        expect_at(1, K_Y,   2, 340, "c_launch_y");
        expect_at(1, K_DIR, 2, 0,   "c_dir_left");
        expect_at(1, K_FEV, 0, 2'b10, "c_fire_event");
        @(negedge frame_clk);
        hit   = '0;
        shoot = '0;
        expect_at(1, K_ACT, 0, 0, "c_despawn_active");
        expect_at(1, K_X,   2, 0, "c_despawn_x");
        expect_at(1, K_Y,   2, 0, "c_despawn_y");
        @(negedge frame_clk);

        // D: simultaneous fires, facing flip in flight, right-edge despawn, start-screen clear.
        clean();
        sprite_x     = {10'd300, 10'd560};
        facing_right = 2'b01;
        shoot        = 2'b11;
        expect_at(1,  K_ACT, 0, 4'b0101, "d_both_fire");
        expect_at(1,  K_X,   0, 600, "d_x0_launch");
        expect_at(1,  K_X,   2, 260, "d_x2_launch");
        expect_at(1,  K_FEV, 0, 2'b11, "d_fire_event_both");
        expect_at(1,  K_DIR, 0, 1, "d_dir0");
        expect_at(1,  K_DIR, 2, 0, "d_dir2");
        expect_at(2,  K_X,   0, 605, "d_x0_after_flip");
        expect_at(2,  K_X,   2, 255, "d_x2_after_flip");
        expect_at(8,  K_X,   0, 635, "d_x0_last");
        expect_at(8,  K_ACT, 0, 4'b0101, "d_before_edge");
        expect_at(9,  K_ACT, 0, 4'b0100, "d_edge_despawn");
        expect_at(9,  K_X,   0, 0,   "d_edge_x0_zero");
        expect_at(9,  K_X,   2, 220, "d_x2_latched_dir");
        expect_at(18, K_ACT, 0, 4'b1101, "d_three_in_flight");
        expect_at(18, K_X,   0, 520, "d_x0_left_launch");
        expect_at(18, K_DIR, 0, 0,   "d_dir0_left");
        expect_at(18, K_X,   3, 340, "d_x3_launch");
        expect_at(18, K_DIR, 3, 1,   "d_dir3_right");
        expect_at(18, K_X,   2, 175, "d_x2_still_flying");
        expect_at(18, K_FEV, 0, 2'b11, "d_refire_both");
        expect_at(19, K_ACT, 0, 0, "d_enable_clear");
        expect_at(19, K_FEV, 0, 0, "d_enable_fev");
        expect_at(19, K_X,   2, 0, "d_enable_x2");
        expect_at(19, K_X,   3, 0, "d_enable_x3");
        expect_at(20, K_ACT, 0, 0, "d_held_no_fire");
        expect_at(20, K_FEV, 0, 0, "d_held_no_fev");
        expect_at(21, K_FEV, 0, 0, "d_held_no_fev2");
        expect_at(22, K_ACT, 0, 0, "d_idle");
        expect_at(23, K_ACT, 0, 4'b0001, "d_cooldown_cleared");
        expect_at(23, K_X,   0, 520, "d_cooldown_cleared_x");
        expect_at(23, K_FEV, 0, 2'b01, "d_cooldown_cleared_fev");
        @(negedge frame_clk);
        facing_right = 2'b10;
        shoot        = '0;
        repeat (16) @(negedge frame_clk);
        shoot = 2'b11;
        @(negedge frame_clk);
        enable = 1'b0;
        @(negedge frame_clk);
        enable = 1'b1;
        repeat (2) @(negedge frame_clk);
        shoot = '0;
        @(negedge frame_clk);
        shoot = 2'b01;
        @(negedge frame_clk);

        // E: reset asserted mid-flight must clear outputs before the next rising edge.
        @(posedge frame_clk);
        #2;
        Reset_n = 1'b0;
        expect_at(0, K_ACT, 0, 0, "e_async_active");
        expect_at(0, K_X,   0, 0, "e_async_x0");
        expect_at(0, K_Y,   0, 0, "e_async_y0");
        expect_at(0, K_FEV, 0, 0, "e_async_fev");
        repeat (2) @(negedge frame_clk);
        Reset_n = 1'b1;
        shoot   = '0;
        repeat (3) @(negedge frame_clk);

        while (exp_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: expectation for frame %0d left pending", exp_q[0].name, exp_q[0].frame);
            void'(exp_q.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/projectile_engine.md
# projectile_engine

Parametrised projectile manager for the fighter game, clocked once per video frame. It gives each of `NUM_PLAYERS` fighters `SLOTS` independent projectiles with these behaviours:
- rising-edge fire detection
- per-player cooldown
- direction latched at launch
- automatic despawn at the screen edges
- clear on collision acknowledge

It sits between the input/state logic that produces `shoot` and sprite positions, and the collision detector and sprite renderer that consume the projectile coordinates.

## Interface
- `NUM_PLAYERS`, default 2: number of fighters.
- `SLOTS`, default 2: projectiles per fighter.
- `COORD_W`, default 10: coordinate width.
- `SPEED`, default 5: pixels moved per frame.
- `COOLDOWN`, default 16: frames after a fire before the same player may fire again; 0 disables the cooldown.
- `MUZZLE_OFS`, default 40: launch x-offset from `sprite_x`.
- `Y_LAUNCH`, default 340: launch y.
- `X_MAX`, default 639: rightmost legal x.

Ports:
- `frame_clk` in 1: frame clock; the only clock.
- `Reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: low (start screen) clears all state synchronously.
- `shoot` in NUM_PLAYERS: fire request, level-sensitive; edge-detected internally.
- `facing_right` in NUM_PLAYERS: player orientation.
- `sprite_x` in NUM_PLAYERS*COORD_W: player x, packed with player p at bits [p*COORD_W +: COORD_W].
- `hit` in NUM_PLAYERS*SLOTS: collision acknowledge. Slot index is p*SLOTS+s.
- `proj_active` out NUM_PLAYERS*SLOTS: slot live.
- `proj_x`, `proj_y` out NUM_PLAYERS*SLOTS*COORD_W: slot position; 0 when the slot is inactive.
- `proj_dir` out NUM_PLAYERS*SLOTS: 1 = moving right.
- `fire_event` out NUM_PLAYERS: one-cycle pulse, high the cycle after a fire is accepted.

## Operation
- Rising edge: `shoot_q` holds the previous sample. rise = `shoot & ~shoot_q`.
- A fire for player p is accepted when all three hold:
  - rise[p];
  - cooldown[p] == 0;
  - at least one slot of p is inactive, judged on the pre-edge state.
- Slot allocation: the lowest-index inactive slot of p is filled.
- Launch x: `sprite_x + MUZZLE_OFS` when facing right; `sprite_x - MUZZLE_OFS` when facing left, saturating at 0.
- If the computed launch x exceeds `X_MAX`, the fire is rejected. The cooldown is not loaded and `fire_event` does not pulse.
- On launch: y = `Y_LAUNCH`, and `proj_dir` latches `facing_right`. Later flips do not affect a projectile in flight.
- Active slot, each frame:
  - `hit` set: the slot goes inactive. Hit has priority over motion.
  - Otherwise x moves by ±`SPEED`, computed in COORD_W+1 bits.
  - If the result is > `X_MAX` or < 0, the slot goes inactive (despawn) and its x/y outputs go to 0.
- `hit` on an inactive slot is ignored.
- Cooldown: on an accepted fire, cooldown[p] loads `COOLDOWN`. Otherwise it decrements toward 0 and saturates there.
- `enable` low, each frame:
  - all slots inactive, cooldowns 0, `fire_event` 0;
  - `shoot_q` keeps tracking `shoot`, so a button held across the start screen does not fire.
- Players are fully independent. Simultaneous fires by different players are both accepted.

## Timing
- Reset values:
  - all `proj_active`, `proj_x`, `proj_y`, `proj_dir` 0;
  - `fire_event` 0;
  - cooldowns 0;
  - `shoot_q` 0.
- Fire latency: `shoot` rises before edge k. After edge k, the slot is active at the launch x and `fire_event` is high for that one cycle.
- First motion: after edge k+1, x = launch x ± `SPEED`.
- Hit latency: `hit` high before edge k clears the slot after edge k. That slot can be re-allocated by a fire at edge k+1 at the earliest.
- Cooldown: after a fire at edge k, the next accepted fire is at edge k+`COOLDOWN`+1 at the earliest, and requires a fresh rising edge.
- Reset mid-flight: all outputs clear immediately, asynchronously.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package `proj_pkg` holds:
  - `dir_t` typedef (LEFT=0, RIGHT=1);
  - a `proj_slot_t` struct {active, dir, x, y};
  - default constants for speed, offsets and `X_MAX`.
- Sub-module `projectile_slot` covers one slot:
  - load, move, despawn and hit logic;
  - per-slot parameters `SPEED` and `X_MAX`.
- Top level contains:
  - a generate loop over players × slots;
  - per-player edge detect, cooldown counter and priority allocator.

## Test plan
- Reset_n low, then high; P0 `shoot` 0→1 with `sprite_x`=200, facing right. Required:
  - slot 0 active at x=240, y=340 one frame later;
  - x=245, 250, … on subsequent frames;
  - `fire_event`[0] pulses once.
- Hold `shoot` high for 50 frames. Required: exactly one fire. With `COOLDOWN`=16, toggling every 4 frames gives fires only at edges spaced ≥17 frames apart.
- P1 at `sprite_x`=30, facing left, fires. Required:
  - launch x=0 (saturated);
  - slot despawns on the next frame, giving `proj_active`=0 and `proj_x`=0.
- Fill both P0 slots, then a third rising edge after cooldown expires. Required: rejected, no `fire_event`. Then `hit`[1] clears slot 1; the next fire takes slot 1 while slot 0 keeps moving.
- Launch facing right, flip `facing_right` mid-flight. Required: x keeps increasing until x>634 would overflow, then despawn.
- `enable` low while 3 projectiles are in flight. Required: all clear next frame. Asserting Reset_n mid-flight clears asynchronously before the next edge.
